// File: rtl/nbseq_pkg.sv
// Shared definitions for the mod-6 non-binary sequence decoder.
// Covers the legal codes, the FSM states and the code-to-position/successor mapping.
package nbseq_pkg;

  localparam int unsigned CODE_W = 3;
  localparam int unsigned IDX_W  = 3;

  localparam logic [CODE_W-1:0] C0 = 3'b000;
  localparam logic [CODE_W-1:0] C1 = 3'b001;
  localparam logic [CODE_W-1:0] C2 = 3'b010;
  localparam logic [CODE_W-1:0] C3 = 3'b100;
  localparam logic [CODE_W-1:0] C4 = 3'b101;
  localparam logic [CODE_W-1:0] C5 = 3'b110;

  localparam logic [IDX_W-1:0] IDX_ILLEGAL = 3'd7;

  typedef enum logic [1:0] {HUNT, ACQ, LOCKED} state_t;

  typedef struct packed {
    logic              legal;
    logic [IDX_W-1:0]  index;
    logic [CODE_W-1:0] succ;
  } map_t;

  // Position and successor of a code; 011 and 111 have neither.
  function automatic map_t nb_map(input logic [CODE_W-1:0] code);
    map_t m;
    m = '{legal: 1'b0, index: IDX_ILLEGAL, succ: C0};
    case (code)
      C0:      m = '{legal: 1'b1, index: 3'd0, succ: C1};
      C1:      m = '{legal: 1'b1, index: 3'd1, succ: C2};
      C2:      m = '{legal: 1'b1, index: 3'd2, succ: C3};
      C3:      m = '{legal: 1'b1, index: 3'd3, succ: C4};
      C4:      m = '{legal: 1'b1, index: 3'd4, succ: C5};
      C5:      m = '{legal: 1'b1, index: 3'd5, succ: C0};
      default: m = '{legal: 1'b0, index: IDX_ILLEGAL, succ: C0};
    endcase
    return m;
  endfunction

endpackage

// File: rtl/nbseq_map.sv
// Combinational decode of one sequence code into index, legality and successor.
import nbseq_pkg::*;

module nbseq_map (
  input  logic [CODE_W-1:0] code,
  output logic [IDX_W-1:0]  index_c,
  output logic              legal_c,
  output logic [CODE_W-1:0] succ_c
);

  map_t m;

  assign m       = nb_map(code);
  assign index_c = m.index;
  assign legal_c = m.legal;
  assign succ_c  = m.succ;

endmodule

// File: rtl/nbseq_decoder.sv
// Tracks a mod-6 non-binary counter stream: hunts, acquires and locks onto the
// sequence, flagging illegal codes, sequence breaks and completed wraps.
import nbseq_pkg::*;

module nbseq_decoder #(
  parameter int unsigned LOCK_LEN = 2,
  parameter int unsigned CNT_W    = 8
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              code_valid,
  input  logic [2:0]        code,
  output logic              out_valid,
  output logic [2:0]        index,
  output logic              locked,
  output logic              illegal,
  output logic              seq_err,
  output logic [CNT_W-1:0]  wrap_count
);

  localparam int unsigned RUN_W = 3;

  state_t             state, state_n;
  logic [RUN_W-1:0]   run, run_n;
  logic [CODE_W-1:0]  prev_code, prev_n;
  logic [CODE_W-1:0]  exp_code, exp_n;
  logic [CNT_W-1:0]   wrap_n;
  logic               ill_n, se_n;

  logic [IDX_W-1:0]   index_c;
  logic               legal_c;
  logic [CODE_W-1:0]  succ_c;
  logic               seq_ok_c;

  nbseq_map u_map (
    .code    (code),
    .index_c (index_c),
    .legal_c (legal_c),
    .succ_c  (succ_c)
  );

  // exp_code caches succ(prev_code) so only the incoming code needs decoding.
  assign seq_ok_c = legal_c && (code == exp_code);

  always_comb begin
    state_n = state;
    run_n   = run;
    prev_n  = prev_code;
    exp_n   = exp_code;
    wrap_n  = wrap_count;
    ill_n   = 1'b0;
    se_n    = 1'b0;
    if (code_valid) begin
      ill_n = !legal_c;
      if (legal_c) begin
        prev_n = code;
        exp_n  = succ_c;
      end
      case (state)
        HUNT: begin
          if (legal_c) begin
            state_n = ACQ;
            run_n   = '0;
          end
        end
        ACQ: begin
          if (!legal_c) begin
            state_n = HUNT;
          end else if (seq_ok_c) begin
            run_n = run + RUN_W'(1);
            if (run_n == RUN_W'(LOCK_LEN)) state_n = LOCKED;
          end else begin
            run_n = '0;
          end
        end
        LOCKED: begin
          if (seq_ok_c) begin
            if (prev_code == C5) wrap_n = wrap_count + CNT_W'(1);
          end else begin
            se_n    = 1'b1;
            run_n   = '0;
            state_n = legal_c ? ACQ : HUNT;
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state      <= HUNT;
      run        <= '0;
      prev_code  <= C0;
      exp_code   <= C1;
      out_valid  <= 1'b0;
      index      <= '0;
      locked     <= 1'b0;
      illegal    <= 1'b0;
      seq_err    <= 1'b0;
      wrap_count <= '0;
    end else begin
      state      <= state_n;
      run        <= run_n;
      prev_code  <= prev_n;
      exp_code   <= exp_n;
      out_valid  <= code_valid;
      if (code_valid) index <= index_c;
      locked     <= (state_n == LOCKED);
      illegal    <= ill_n;
      seq_err    <= se_n;
      wrap_count <= wrap_n;
    end
  end

endmodule

// File: tb/tb_nbseq_decoder.sv
// Self-checking bench for nbseq_decoder: directed scenarios plus a random stream
// compared against a position-based reference model.
module tb_nbseq_decoder;

  localparam int LOCK_LEN = 2;

  logic       clk = 1'b0;
  logic       clear;
  logic       code_valid;
  logic [2:0] code;

  logic       ov_a, lk_a, il_a, se_a;
  logic [2:0] ix_a;
  logic [7:0] wc_a;
  logic       ov_b, lk_b, il_b, se_b;
  logic [2:0] ix_b;
  logic [1:0] wc_b;

  nbseq_decoder #(.LOCK_LEN(LOCK_LEN), .CNT_W(8)) u_dut (
    .clk(clk), .clear(clear), .code_valid(code_valid), .code(code),
    .out_valid(ov_a), .index(ix_a), .locked(lk_a), .illegal(il_a),
    .seq_err(se_a), .wrap_count(wc_a)
  );

  nbseq_decoder #(.LOCK_LEN(LOCK_LEN), .CNT_W(2)) u_dut_narrow (
    .clk(clk), .clear(clear), .code_valid(code_valid), .code(code),
    .out_valid(ov_b), .index(ix_b), .locked(lk_b), .illegal(il_b),
    .seq_err(se_b), .wrap_count(wc_b)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [2:0] seq_tab [6] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110};

  // Reference model: 0=hunt 1=acq 2=locked, sequence tracked as positions 0..5.
  int         m_st, m_run, m_prev_pos, m_wrap;
  logic       e_ov, e_lock, e_ill, e_se;
  logic [2:0] e_idx;

  logic [14:0] act_a, act_b_full;
  logic [8:0]  act_b;
  assign act_a = {ov_a, ix_a, lk_a, il_a, se_a, wc_a};
  assign act_b = {ov_b, ix_b, lk_b, il_b, se_b, wc_b};
  assign act_b_full = {6'd0, act_b};

  function automatic int pos_of(input logic [2:0] c);
    for (int i = 0; i < 6; i++) if (seq_tab[i] == c) return i;
    return -1;
  endfunction

  function automatic logic [14:0] exp_a();
    return {e_ov, e_idx, e_lock, e_ill, e_se, 8'(m_wrap)};
  endfunction

  function automatic logic [8:0] exp_b();
    return {e_ov, e_idx, e_lock, e_ill, e_se, 2'(m_wrap)};
  endfunction

  task automatic model_update(input logic v, input logic [2:0] c, input logic clr);
    int p, nxt;
    if (clr) begin
      m_st = 0; m_run = 0; m_prev_pos = 0; m_wrap = 0;
      e_ov = 0; e_lock = 0; e_ill = 0; e_se = 0; e_idx = 3'd0;
    end else begin
      e_ov = v; e_ill = 0; e_se = 0;
      if (v) begin
        p   = pos_of(c);
        nxt = (m_prev_pos + 1) % 6;
        e_idx = (p < 0) ? 3'd7 : 3'(p);
        e_ill = (p < 0);
        case (m_st)
          0: if (p >= 0) begin m_st = 1; m_run = 0; m_prev_pos = p; end
          1: begin
            if (p < 0) m_st = 0;
            else begin
              if (p == nxt) begin
                m_run++;
                if (m_run == LOCK_LEN) m_st = 2;
              end else m_run = 0;
              m_prev_pos = p;
            end
          end
          default: begin
            if (p >= 0 && p == nxt) begin
              if (p == 0) m_wrap++;
              m_prev_pos = p;
            end else begin
              e_se = 1;
              if (p >= 0) begin m_st = 1; m_run = 0; m_prev_pos = p; end
              else m_st = 0;
            end
          end
        endcase
      end
      e_lock = (m_st == 2);
    end
  endtask

  task automatic step(input logic v, input logic [2:0] c, input logic clr);
    clear = clr; code_valid = v; code = c;
    @(posedge clk);
    model_update(v, c, clr);
    #1;
  endtask

  task automatic go_locked();
    step(1'b0, 3'b000, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, seq_tab[i], 1'b0);
  endtask

  task automatic test_reset();
    step(1'b1, 3'b010, 1'b1);
    checks++;
    if (act_a !== 15'd0) begin errors++; $display("FAIL reset_wide got=%h exp=0", act_a); end
    checks++;
    if (act_b !== 9'd0) begin errors++; $display("FAIL reset_narrow got=%h exp=0", act_b); end
  endtask

  task automatic test_lock();
    step(1'b0, 3'b000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, seq_tab[i], 1'b0);
      checks++;
      if (act_a !== exp_a()) begin errors++; $display("FAIL lock_step%0d got=%h exp=%h", i, act_a, exp_a()); end
      checks++;
      if (ix_a !== 3'(i) || il_a !== 1'b0 || se_a !== 1'b0 || lk_a !== (i == 2)) begin
        errors++; $display("FAIL lock_const%0d idx=%0d lk=%b il=%b se=%b", i, ix_a, lk_a, il_a, se_a);
      end
    end
  endtask

  task automatic test_wrap();
    go_locked();
    for (int k = 0; k < 40; k++) begin
      step(1'b1, seq_tab[(3 + k) % 6], 1'b0);
      checks++;
      if (act_a !== exp_a() || se_a !== 1'b0) begin
        errors++; $display("FAIL wrap_step%0d got=%h exp=%h", k, act_a, exp_a());
      end
    end
    checks++;
    if (wc_a !== 8'd7) begin errors++; $display("FAIL wrap_total got=%0d exp=7", wc_a); end
  endtask

  task automatic test_seq_err();
    go_locked();
    step(1'b1, 3'b101, 1'b0);
    checks++;
    if (se_a !== 1'b1 || lk_a !== 1'b0 || act_a !== exp_a()) begin
      errors++; $display("FAIL seqerr_pulse got=%h exp=%h", act_a, exp_a());
    end
    step(1'b1, 3'b110, 1'b0);
    checks++;
    if (se_a !== 1'b0 || lk_a !== 1'b0 || act_a !== exp_a()) begin
      errors++; $display("FAIL seqerr_acq got=%h exp=%h", act_a, exp_a());
    end
    step(1'b1, 3'b000, 1'b0);
    checks++;
    if (lk_a !== 1'b1 || wc_a !== 8'd0 || act_a !== exp_a()) begin
      errors++; $display("FAIL seqerr_relock got=%h exp=%h", act_a, exp_a());
    end
  endtask

  task automatic test_illegal();
    step(1'b0, 3'b000, 1'b1);
    step(1'b1, 3'b011, 1'b0);
    checks++;
    if (il_a !== 1'b1 || ix_a !== 3'd7 || se_a !== 1'b0 || act_a !== exp_a()) begin
      errors++; $display("FAIL illegal_hunt got=%h exp=%h", act_a, exp_a());
    end
    step(1'b1, 3'b000, 1'b0);
    step(1'b1, 3'b111, 1'b0);
    checks++;
    if (il_a !== 1'b1 || ix_a !== 3'd7 || se_a !== 1'b0 || act_a !== exp_a()) begin
      errors++; $display("FAIL illegal_acq got=%h exp=%h", act_a, exp_a());
    end
    go_locked();
    step(1'b1, 3'b011, 1'b0);
    checks++;
    if (il_a !== 1'b1 || se_a !== 1'b1 || ix_a !== 3'd7 || lk_a !== 1'b0 || act_a !== exp_a()) begin
      errors++; $display("FAIL illegal_locked got=%h exp=%h", act_a, exp_a());
    end
    step(1'b1, 3'b001, 1'b0);
    step(1'b1, 3'b010, 1'b0);
    step(1'b1, 3'b100, 1'b0);
    checks++;
    if (lk_a !== 1'b1 || act_a !== exp_a()) begin
      errors++; $display("FAIL illegal_recover got=%h exp=%h", act_a, exp_a());
    end
  endtask

  task automatic test_clear_gaps();
    go_locked();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 3'b111, 1'b0);
      checks++;
      if (ov_a !== 1'b0 || lk_a !== 1'b1 || ix_a !== 3'd2 || il_a !== 1'b0 || se_a !== 1'b0) begin
        errors++; $display("FAIL gap%0d got=%h exp=%h", i, act_a, exp_a());
      end
    end
    step(1'b1, 3'b100, 1'b0);
    checks++;
    if (lk_a !== 1'b1 || se_a !== 1'b0 || act_a !== exp_a()) begin
      errors++; $display("FAIL gap_resume got=%h exp=%h", act_a, exp_a());
    end
    step(1'b1, 3'b101, 1'b1);
    checks++;
    if (act_a !== 15'd0 || act_b !== 9'd0) begin
      errors++; $display("FAIL clear_locked got=%h exp=0", act_a);
    end
  endtask

  task automatic test_wrap_narrow();
    go_locked();
    for (int k = 0; k < 30; k++) step(1'b1, seq_tab[(3 + k) % 6], 1'b0);
    checks++;
    if (wc_b !== 2'd1) begin errors++; $display("FAIL wrap_narrow got=%0d exp=1", wc_b); end
    checks++;
    if (wc_a !== 8'd5) begin errors++; $display("FAIL wrap_wide5 got=%0d exp=5", wc_a); end
  endtask

  task automatic test_random();
    int dpos, r;
    logic [2:0] c;
    step(1'b0, 3'b000, 1'b1);
    dpos = 5;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r == 99) step(1'b1, 3'(r), 1'b1);
      else if (r < 10) step(1'b0, 3'($urandom_range(0, 7)), 1'b0);
      else begin
        if (r < 82) begin
          dpos = (dpos + 1) % 6;
          c = seq_tab[dpos];
        end else begin
          c = 3'($urandom_range(0, 7));
          if (pos_of(c) >= 0) dpos = pos_of(c);
        end
        step(1'b1, c, 1'b0);
      end
      checks++;
      if (act_a !== exp_a()) begin errors++; $display("FAIL rand_wide%0d got=%h exp=%h", n, act_a, exp_a()); end
      checks++;
      if (act_b !== exp_b()) begin errors++; $display("FAIL rand_narrow%0d got=%h exp=%h", n, act_b_full, {6'd0, exp_b()}); end
    end
  endtask

  initial begin
    clear = 1'b1; code_valid = 1'b0; code = 3'b000;
    test_reset();
    test_lock();
    test_wrap();
    test_seq_err();
    test_illegal();
    test_clear_gaps();
    test_wrap_narrow();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nbseq_decoder.md
NBSEQ_DECODER -- requirements
Module: nbseq_decoder

Interface
REQ-001 Parameter LOCK_LEN, default 2: consecutive correct successor transitions required to enter LOCKED; legal range 1..7.
REQ-002 Parameter CNT_W, default 8: width of wrap_count.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 clear  input  1  reset, synchronous, active-high.
REQ-005 code_valid  input  1  code is sampled this cycle.
REQ-006 code  input  3  next state word from the mod-6 non-binary counter (sequence 000,001,010,100,101,110, then back to 000).
REQ-007 out_valid  output  1  registered; high one cycle after each sampled code.
REQ-008 index  output  3  registered binary position of the last sampled code: 000->0, 001->1, 010->2, 100->3, 101->4, 110->5; 7 for an illegal code.
REQ-009 locked  output  1  registered; high while the FSM is in LOCKED.
REQ-010 illegal  output  1  registered one-cycle pulse; the sampled code was 011 or 111.
REQ-011 seq_err  output  1  registered one-cycle pulse; a sampled code broke the sequence while LOCKED.
REQ-012 wrap_count  output  CNT_W  count of completed sequence cycles seen while LOCKED.

Function
REQ-013 The block SHALL act only on cycles with code_valid=1; with code_valid=0, every register except out_valid, illegal and seq_err SHALL hold, and those three SHALL be 0.
REQ-014 Latency SHALL be exactly one cycle from a sampled code to out_valid, index, illegal, seq_err and locked.
REQ-015 Successor function: 000->001->010->100->101->110->000; codes 011 and 111 have no successor.
REQ-016 FSM states SHALL be HUNT, ACQ and LOCKED; prev_code register holds the last legal sampled code.
REQ-017 HUNT: legal code -> ACQ with run counter=0, prev_code=code; illegal code -> stay in HUNT.
REQ-018 ACQ: code = succ(prev_code) -> increment run counter; when the counter reaches LOCK_LEN -> LOCKED; other legal code -> stay in ACQ with run=0; illegal code -> HUNT; prev_code updates on every legal code.
REQ-019 LOCKED: code = succ(prev_code) -> stay; otherwise seq_err=1, then a legal code -> ACQ with run=0 and prev_code=code, an illegal code -> HUNT (illegal=1 as well).
REQ-020 Repeated code (no advance) while LOCKED SHALL be a sequence error.
REQ-021 wrap_count SHALL increment by 1 when LOCKED accepts the transition 110->000, and SHALL wrap modulo 2^CNT_W with no saturation and no flag.
REQ-022 The transition that completes lock SHALL NOT increment wrap_count even if it is 110->000.
REQ-023 illegal SHALL be reported in every state; seq_err only in LOCKED.

Reset
REQ-024 clear=1 at a clock edge SHALL force: state HUNT, run=0, prev_code=000, out_valid=0, index=0, locked=0, illegal=0, seq_err=0, wrap_count=0.
REQ-025 clear SHALL take priority over a simultaneous code_valid; the code sampled in that cycle is discarded.
REQ-026 clear asserted mid-lock SHALL drop locked on the following edge, with no seq_err.

Structure
REQ-027 Package nbseq_pkg SHALL hold the six legal code constants, the state enum (HUNT, ACQ, LOCKED) and the successor/index mapping function.
REQ-028 A combinational sub-module nbseq_map SHALL compute index, legal and succ from a 3-bit code; the FSM, counters and output registers live in nbseq_decoder.

Verification
REQ-029 Reset, then a valid stream 000,001,010 with LOCK_LEN=2 -> locked=1 one cycle after 010 is sampled, index sequence 0,1,2, no pulses.
REQ-030 Locked, then 40 consecutive valid codes of the full sequence starting at 100 -> wrap_count=7 at the end, seq_err never asserted.
REQ-031 Locked at 010, then code 101 -> seq_err=1 for one cycle, locked=0, state ACQ; a following 110 then 000 -> locked=1 again.
REQ-032 Code 011 in any state -> illegal=1, index=7; from LOCKED -> seq_err=1 and HUNT.
REQ-033 CNT_W=2, 5 full sequence cycles while LOCKED -> wrap_count reads 1.
REQ-034 clear together with code_valid=1 while LOCKED -> all outputs 0 next cycle; gaps with code_valid=0 inside a locked stream -> no error and no state change.
